// File: rtl/alu_seq_issue.sv
// -----------------------------------------------------------------------------
// alu_seq_issue
//
// Single-issue sequential ALU. A request is accepted in IDLE when start_i is
// high. Ordinary operations take one cycle to produce a result. MUL uses an
// iterative shift-add multiplier that takes 32 cycles. The result is held
// with valid_o until the consumer acknowledges it.
//
// Supported operations (ALUCtrl_o code):
//   AND=000 XOR=001 SLL=010 ADD=011 SUB=100 MUL=101 ADDI=110 SRAI=111
// Any request that does not decode is flagged with illegal_o. It still takes
// one cycle and returns data_o = 0 and ALUCtrl_o = 000.
//
// Ports
//   clk_i      in   1   clock; all state changes on the rising edge
//   rst_i      in   1   asynchronous, active-high reset
//   start_i    in   1   request valid; accepted when start_i && ready_o
//   funct7_i   in   7   instruction funct7 field
//   funct3_i   in   3   instruction funct3 field
//   is_imm_i   in   1   1 = I-type (ADDI/SRAI), 0 = R-type
//   data1_i    in  32   operand 1
//   data2_i    in  32   operand 2 (sign-extended immediate for I-type)
//   ack_i      in   1   consumer takes the result (only looked at in DONE)
//   ready_o    out  1   high only in IDLE
//   valid_o    out  1   result valid, held until ack_i
//   data_o     out 32   registered result
//   ALUCtrl_o  out  3   decoded control code of the accepted request
//   Zero_o     out  1   captured data1 == data2
//   illegal_o  out  1   accepted request did not decode
// -----------------------------------------------------------------------------
module alu_seq_issue (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [6:0]  funct7_i,
    input  logic [2:0]  funct3_i,
    input  logic        is_imm_i,
    input  logic [31:0] data1_i,
    input  logic [31:0] data2_i,
    input  logic        ack_i,
    output logic        ready_o,
    output logic        valid_o,
    output logic [31:0] data_o,
    output logic [2:0]  ALUCtrl_o,
    output logic        Zero_o,
    output logic        illegal_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_MUL,
        S_DONE
    } state_t;

    typedef enum logic [2:0] {
        ALU_AND  = 3'b000,
        ALU_XOR  = 3'b001,
        ALU_SLL  = 3'b010,
        ALU_ADD  = 3'b011,
        ALU_SUB  = 3'b100,
        ALU_MUL  = 3'b101,
        ALU_ADDI = 3'b110,
        ALU_SRAI = 3'b111
    } alu_ctrl_t;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MULD = 7'b0000001;

    state_t      state_q;
    state_t      state_d;

    alu_ctrl_t   dec_ctrl;
    logic        dec_illegal;
    logic        accept;

    // Operands captured at accept, used by the single-cycle path.
    logic [31:0] op_a;
    logic [31:0] op_b;
    alu_ctrl_t   ctrl_q;
    logic [31:0] exec_result;

    // Shift-add multiplier. mcand moves left and mplier moves right, so each
    // cycle adds mcand to acc when mplier[0] is set.
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [31:0] acc;
    logic [4:0]  mul_cnt;
    logic [31:0] mul_acc_next;
    logic        mul_last;

    // -------------------------------------------------------------------------
    // Request decode
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default before any branch.
        // A path that leaves a signal unassigned would otherwise infer a latch.
        dec_ctrl    = ALU_AND;
        dec_illegal = 1'b1;
        if (is_imm_i) begin
            if (funct3_i == 3'b000) begin
                dec_ctrl    = ALU_ADDI;     // funct7 carries immediate bits
                dec_illegal = 1'b0;
            end else if (funct3_i == 3'b101 && funct7_i == F7_ALT) begin
                dec_ctrl    = ALU_SRAI;
                dec_illegal = 1'b0;
            end
        end else begin
            case ({funct7_i, funct3_i})
                {F7_BASE, 3'b111}: begin dec_ctrl = ALU_AND; dec_illegal = 1'b0; end
                {F7_BASE, 3'b100}: begin dec_ctrl = ALU_XOR; dec_illegal = 1'b0; end
                {F7_BASE, 3'b001}: begin dec_ctrl = ALU_SLL; dec_illegal = 1'b0; end
                {F7_BASE, 3'b000}: begin dec_ctrl = ALU_ADD; dec_illegal = 1'b0; end
                {F7_ALT,  3'b000}: begin dec_ctrl = ALU_SUB; dec_illegal = 1'b0; end
                {F7_MULD, 3'b000}: begin dec_ctrl = ALU_MUL; dec_illegal = 1'b0; end
                default:           begin dec_ctrl = ALU_AND; dec_illegal = 1'b1; end
            endcase
        end
    end

    assign accept = start_i && ready_o;

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            // NOTE: registers use non-blocking assignment. Every flop then
            // samples pre-edge values, whatever order the blocks run in.
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ready_o = 1'b0;
        valid_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                ready_o = 1'b1;
                // An illegal request decodes as AND, so only a real MUL goes
                // to the multi-cycle path.
                if (start_i) begin
                    state_d = (dec_ctrl == ALU_MUL) ? S_MUL : S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_DONE;
            end
            S_MUL: begin
                if (mul_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                valid_o = 1'b1;
                if (ack_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Single-cycle result from the captured operands
    // -------------------------------------------------------------------------
    always_comb begin
        exec_result = '0;
        if (!illegal_o) begin
            case (ctrl_q)
                ALU_AND:  exec_result = op_a & op_b;
                ALU_XOR:  exec_result = op_a ^ op_b;
                ALU_SLL:  exec_result = op_a << op_b[4:0];
                ALU_ADD,
                ALU_ADDI: exec_result = op_a + op_b;
                ALU_SUB:  exec_result = op_a - op_b;
                ALU_SRAI: exec_result = $signed(op_a) >>> op_b[4:0];
                default:  exec_result = '0;       // MUL never reaches EXEC
            endcase
        end
    end

    // The last iteration folds its partial product straight into data_o. The
    // result therefore lands on the 32nd edge after accept.
    assign mul_acc_next = acc + (mplier[0] ? mcand : 32'd0);
    assign mul_last     = (mul_cnt == 5'd31);

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_a      <= '0;
            op_b      <= '0;
            ctrl_q    <= ALU_AND;
            illegal_o <= 1'b0;
            Zero_o    <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            mul_cnt   <= '0;
            data_o    <= '0;
        end else begin
            if (accept) begin
                op_a      <= data1_i;
                op_b      <= data2_i;
                ctrl_q    <= dec_ctrl;
                illegal_o <= dec_illegal;
                Zero_o    <= (data1_i == data2_i);
                mcand     <= data1_i;
                mplier    <= data2_i;
                acc       <= '0;
                mul_cnt   <= '0;
            end

            if (state_q == S_EXEC) begin
                data_o <= exec_result;
            end

            if (state_q == S_MUL) begin
                acc     <= mul_acc_next;
                mcand   <= mcand << 1;
                mplier  <= mplier >> 1;
                mul_cnt <= mul_cnt + 5'd1;
                if (mul_last) begin
                    data_o <= mul_acc_next;
                end
            end
        end
    end

    assign ALUCtrl_o = ctrl_q;

endmodule

// File: tb/tb_alu_seq_issue.sv
// -----------------------------------------------------------------------------
// tb_alu_seq_issue
//
// Directed bench for alu_seq_issue. A behavioural model works out the
// expected outputs from the operation rules and the handshake latencies.
// A compare process checks every output against it on every falling edge.
// Directed sections pin literal expected values for the corner cases.
// -----------------------------------------------------------------------------
module tb_alu_seq_issue;

    logic        clk_i;
    logic        rst_i;
    logic        start_i;
    logic [6:0]  funct7_i;
    logic [2:0]  funct3_i;
    logic        is_imm_i;
    logic [31:0] data1_i;
    logic [31:0] data2_i;
    logic        ack_i;
    logic        ready_o;
    logic        valid_o;
    logic [31:0] data_o;
    logic [2:0]  ALUCtrl_o;
    logic        Zero_o;
    logic        illegal_o;

    int n_cmp  = 0;
    int n_fail = 0;

    alu_seq_issue dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .funct7_i  (funct7_i),
        .funct3_i  (funct3_i),
        .is_imm_i  (is_imm_i),
        .data1_i   (data1_i),
        .data2_i   (data2_i),
        .ack_i     (ack_i),
        .ready_o   (ready_o),
        .valid_o   (valid_o),
        .data_o    (data_o),
        .ALUCtrl_o (ALUCtrl_o),
        .Zero_o    (Zero_o),
        .illegal_o (illegal_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Behavioural model
    // -------------------------------------------------------------------------
    typedef struct packed {
        logic [2:0]  ctrl;
        logic        ill;
        logic        is_mul;
        logic [31:0] res;
    } op_t;

    function automatic op_t model_op(input logic [6:0] f7, input logic [2:0] f3,
                                     input logic imm, input logic [31:0] a,
                                     input logic [31:0] b);
        op_t         r;
        logic [63:0] prod;
        r    = '0;
        prod = {32'd0, a} * {32'd0, b};
        if (imm) begin
            if (f3 == 3'b000) begin
                r.ctrl = 3'b110; r.res = a + b;
            end else if (f3 == 3'b101 && f7 == 7'b0100000) begin
                r.ctrl = 3'b111; r.res = $signed(a) >>> b[4:0];
            end else begin
                r.ill = 1'b1;
            end
        end else if (f7 == 7'b0000000 && f3 == 3'b111) begin
            r.ctrl = 3'b000; r.res = a & b;
        end else if (f7 == 7'b0000000 && f3 == 3'b100) begin
            r.ctrl = 3'b001; r.res = a ^ b;
        end else if (f7 == 7'b0000000 && f3 == 3'b001) begin
            r.ctrl = 3'b010; r.res = a << b[4:0];
        end else if (f7 == 7'b0000000 && f3 == 3'b000) begin
            r.ctrl = 3'b011; r.res = a + b;
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
            r.ctrl = 3'b100; r.res = a - b;
        end else if (f7 == 7'b0000001 && f3 == 3'b000) begin
            r.ctrl = 3'b101; r.res = prod[31:0]; r.is_mul = 1'b1;
        end else begin
            r.ill = 1'b1;
        end
        return r;
    endfunction

    function automatic int latency_of(input op_t r);
        return r.is_mul ? 32 : 1;
    endfunction

    op_t         cur    = '0;   // request captured at the last accept
    int          remain = 0;    // edges until the result appears
    logic        m_valid = 1'b0;
    logic        m_zero  = 1'b0;
    logic [31:0] m_data  = '0;
    logic        m_ready;

    assign m_ready = (remain == 0) && !m_valid;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cur     <= '0;
            remain  <= 0;
            m_valid <= 1'b0;
            m_zero  <= 1'b0;
            m_data  <= '0;
        end else if (m_ready) begin
            if (start_i) begin
                cur    <= model_op(funct7_i, funct3_i, is_imm_i, data1_i, data2_i);
                remain <= latency_of(model_op(funct7_i, funct3_i, is_imm_i, data1_i, data2_i));
                m_zero <= (data1_i == data2_i);
            end
        end else if (remain > 0) begin
            remain <= remain - 1;
            if (remain == 1) begin
                m_data  <= cur.ill ? 32'd0 : cur.res;
                m_valid <= 1'b1;
            end
        end else if (ack_i) begin
            m_valid <= 1'b0;
        end
    end

    always @(negedge clk_i) begin
        check("cmp_ready",   32'(ready_o),   32'(m_ready));
        check("cmp_valid",   32'(valid_o),   32'(m_valid));
        check("cmp_data",    data_o,         m_data);
        check("cmp_ctrl",    32'(ALUCtrl_o), 32'(cur.ill ? 3'b000 : cur.ctrl));
        check("cmp_zero",    32'(Zero_o),    32'(m_zero));
        check("cmp_illegal", 32'(illegal_o), 32'(cur.ill));
    end

    // -------------------------------------------------------------------------
    // Driver helpers
    // -------------------------------------------------------------------------
    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_req(input logic [6:0] f7, input logic [2:0] f3, input logic imm,
                           input logic [31:0] a, input logic [31:0] b);
        funct7_i = f7;
        funct3_i = f3;
        is_imm_i = imm;
        data1_i  = a;
        data2_i  = b;
    endtask

    task automatic issue(input logic [6:0] f7, input logic [2:0] f3, input logic imm,
                         input logic [31:0] a, input logic [31:0] b);
        set_req(f7, f3, imm, a, b);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!valid_o && n < budget) begin
            tick();
            n++;
        end
        if (!valid_o) check("valid_timeout", 32'(valid_o), 32'd1);
    endtask

    task automatic do_ack;
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
    endtask

    task automatic run_op(input logic [6:0] f7, input logic [2:0] f3, input logic imm,
                          input logic [31:0] a, input logic [31:0] b);
        issue(f7, f3, imm, a, b);
        wait_valid(40);
        do_ack();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"},   32'(ready_o),   32'd1);
        check({tag, "_valid"},   32'(valid_o),   32'd0);
        check({tag, "_data"},    data_o,         32'd0);
        check({tag, "_ctrl"},    32'(ALUCtrl_o), 32'd0);
        check({tag, "_zero"},    32'(Zero_o),    32'd0);
        check({tag, "_illegal"}, 32'(illegal_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    // -------------------------------------------------------------------------
    // Directed stimulus
    // -------------------------------------------------------------------------
    initial begin
        rst_i = 1'b0; start_i = 1'b0; ack_i = 1'b0;
        set_req('0, '0, 1'b0, '0, '0);
        #1 rst_i = 1'b1;
        #1 check_reset_values("reset");
        @(posedge clk_i);
        #3 rst_i = 1'b0;
        tick();

        // SUB 5-5: ctrl/Zero right after accept, zero result one edge later
        issue(7'b0100000, 3'b000, 1'b0, 32'd5, 32'd5);
        check("sub_ctrl", 32'(ALUCtrl_o), 32'b100);
        check("sub_zero", 32'(Zero_o), 32'd1);
        check("sub_ready_low", 32'(ready_o), 32'd0);
        tick();
        check("sub_valid", 32'(valid_o), 32'd1);
        check("sub_data", data_o, 32'd0);
        do_ack();

        // MUL 0xFFFFFFFF x 3: busy for 32 edges, then low product bits
        issue(7'b0000001, 3'b000, 1'b0, 32'hFFFF_FFFF, 32'd3);
        for (int i = 0; i < 32; i++) begin
            check("mul_busy_ready", 32'(ready_o), 32'd0);
            check("mul_busy_valid", 32'(valid_o), 32'd0);
            tick();
        end
        check("mul_valid", 32'(valid_o), 32'd1);
        check("mul_ready", 32'(ready_o), 32'd0);
        check("mul_data", data_o, 32'hFFFF_FFFD);
        check("mul_ctrl", 32'(ALUCtrl_o), 32'b101);
        do_ack();

        // SRAI with upper shift bits set, and SLL by 0x21 (shift 1)
        issue(7'b0100000, 3'b101, 1'b1, 32'h8000_0000, 32'h0000_0404);
        check("srai_ctrl", 32'(ALUCtrl_o), 32'b111);
        tick();
        check("srai_data", data_o, 32'hF800_0000);
        do_ack();
        issue(7'b0000000, 3'b001, 1'b0, 32'd1, 32'h21);
        tick();
        check("sll_data", data_o, 32'd2);
        do_ack();

        // Undecodable R-type: flagged, zero result after one cycle
        issue(7'b0000000, 3'b010, 1'b0, 32'h1234, 32'h5678);
        check("ill_flag", 32'(illegal_o), 32'd1);
        check("ill_ctrl", 32'(ALUCtrl_o), 32'd0);
        tick();
        check("ill_valid", 32'(valid_o), 32'd1);
        check("ill_data", data_o, 32'd0);
        do_ack();

        // Held result with start_i kept high, then accept one edge after ack
        issue(7'b0000000, 3'b000, 1'b0, 32'd7, 32'd8);
        start_i = 1'b1;
        set_req(7'b0000000, 3'b000, 1'b0, 32'd100, 32'd1);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", 32'(valid_o), 32'd1);
            check("hold_data", data_o, 32'd15);
            check("hold_ready", 32'(ready_o), 32'd0);
            tick();
        end
        do_ack();
        check("post_ack_ready", 32'(ready_o), 32'd1);
        check("post_ack_valid", 32'(valid_o), 32'd0);
        tick();
        start_i = 1'b0;
        check("reaccept_ready", 32'(ready_o), 32'd0);
        check("reaccept_ctrl", 32'(ALUCtrl_o), 32'b011);
        tick();
        check("reaccept_data", data_o, 32'd101);
        do_ack();

        // Mixed operations, checked through the model
        run_op(7'b0000000, 3'b111, 1'b0, 32'hF0F0_1234, 32'hFF00_FF00);  // AND
        run_op(7'b0000000, 3'b100, 1'b0, 32'hA5A5_A5A5, 32'h0F0F_0F0F);  // XOR
        run_op(7'b0000000, 3'b000, 1'b0, 32'hFFFF_FFFF, 32'd2);          // ADD wrap
        run_op(7'b0100000, 3'b000, 1'b0, 32'd3, 32'd5);                  // SUB negative
        run_op(7'b1111111, 3'b000, 1'b1, 32'd10, 32'hFFFF_FFFB);         // ADDI
        run_op(7'b0000001, 3'b000, 1'b0, 32'hFFFF_FFF9, 32'hFFFF_FFF7);  // MUL -7*-9
        run_op(7'b0000001, 3'b000, 1'b0, 32'h0001_0000, 32'h0001_0000);  // MUL overflow
        run_op(7'b0000000, 3'b001, 1'b0, 32'h0000_0003, 32'd31);         // SLL 31
        run_op(7'b0100000, 3'b101, 1'b1, 32'h7FFF_FFFF, 32'hFFFF_FC1F);  // SRAI 31
        run_op(7'b0000000, 3'b001, 1'b1, 32'd9, 32'd9);                  // illegal I
        run_op(7'b0100000, 3'b101, 1'b0, 32'd9, 32'd1);                  // illegal R
        run_op(7'b0000001, 3'b001, 1'b0, 32'd6, 32'd7);                  // illegal MUL f3

        // Reset during MUL iteration 10: immediate clear, no late valid_o
        issue(7'b0000001, 3'b000, 1'b0, 32'h0000_1234, 32'h0000_5678);
        repeat (10) tick();
        #2 rst_i = 1'b1;
        #1 check_reset_values("abort");
        @(posedge clk_i);
        #3 rst_i = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            check("abort_no_valid", 32'(valid_o), 32'd0);
        end

        // Request pending across reset release is taken on the first edge
        rst_i = 1'b1;
        set_req(7'b0000000, 3'b000, 1'b0, 32'd3, 32'd4);
        start_i = 1'b1;
        @(posedge clk_i);
        #3 rst_i = 1'b0;
        tick();
        start_i = 1'b0;
        check("post_rst_ready", 32'(ready_o), 32'd0);
        check("post_rst_ctrl", 32'(ALUCtrl_o), 32'b011);
        tick();
        check("post_rst_valid", 32'(valid_o), 32'd1);
        check("post_rst_data", data_o, 32'd7);
        do_ack();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq_issue.md
ALU_SEQ_ISSUE -- requirements
Module: alu_seq_issue

Interface
REQ-001 SHALL have port: clk_i  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_i  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: start_i  input  1  request valid; accepted when start_i && ready_o at a rising edge.
REQ-004 SHALL have port: funct7_i  input  7  instruction funct7 field.
REQ-005 SHALL have port: funct3_i  input  3  instruction funct3 field.
REQ-006 SHALL have port: is_imm_i  input  1  1 = I-type (ADDI/SRAI), 0 = R-type.
REQ-007 SHALL have ports: data1_i, data2_i  input  32 each  operands (data2_i carries the sign-extended immediate for I-type).
REQ-008 SHALL have port: ack_i  input  1  consumer accepts the result.
REQ-009 SHALL have port: ready_o  output  1  high only in IDLE.
REQ-010 SHALL have port: valid_o  output  1  result valid, held until ack_i.
REQ-011 SHALL have port: data_o  output  32  registered result.
REQ-012 SHALL have port: ALUCtrl_o  output  3  registered decoded control code of the accepted request.
REQ-013 SHALL have ports: Zero_o (1 when captured data1 == data2) and illegal_o (1 when the request did not decode), both output, 1 bit each.

Function
REQ-014 SHALL decode into ALUCtrl codes: AND=000 (R, f7 0000000, f3 111); XOR=001 (R, 0000000, 100); SLL=010 (R, 0000000, 001); ADD=011 (R, 0000000, 000); SUB=100 (R, 0100000, 000); MUL=101 (R, 0000001, 000); ADDI=110 (I, f3 000, funct7 ignored); SRAI=111 (I, f7 0100000, f3 101).
REQ-015 SHALL treat every other combination as illegal: ALUCtrl_o=000, data_o=0, illegal_o=1.
REQ-016 SHALL implement FSM states IDLE, EXEC, MUL, DONE; IDLE -> EXEC on accept of a non-MUL or illegal request; IDLE -> MUL on accept of MUL; EXEC -> DONE after 1 cycle; MUL -> DONE after 32 cycles; DONE -> IDLE on ack_i.
REQ-017 SHALL capture operands, ALUCtrl_o, illegal_o and Zero_o at the accept edge; ALUCtrl_o, illegal_o and Zero_o SHALL stay stable until the next accept.
REQ-018 SHALL, for non-MUL requests accepted at edge N, register data_o and assert valid_o at edge N+1.
REQ-019 SHALL compute MUL with an iterative shift-add multiplier, one multiplier bit per cycle and a 5-bit iteration counter; for MUL accepted at edge N, data_o and valid_o SHALL update at edge N+32.
REQ-020 SHALL keep the MUL result as the low 32 bits of the product (signed and unsigned identical); overflow is discarded.
REQ-021 SHALL compute ADD, ADDI and SUB modulo 2^32, with no carry or overflow output.
REQ-022 SHALL compute SLL as a logical left shift by data2[4:0] and SRAI as an arithmetic right shift by data2[4:0]; data2[31:5] SHALL be ignored.
REQ-023 SHALL hold valid_o=1 and data_o stable in DONE until ack_i is sampled high; valid_o SHALL deassert at that edge.
REQ-024 SHALL hold ready_o=0 in EXEC, MUL and DONE; start_i is ignored there, with no queueing, and a new request is accepted no earlier than one cycle after ack_i.
REQ-025 SHALL ignore ack_i outside DONE.
REQ-026 SHALL keep data_o at its previous value while in EXEC and MUL.

Reset
REQ-027 SHALL, on rst_i high, immediately force state=IDLE, ready_o=1, valid_o=0, data_o=0, ALUCtrl_o=000, Zero_o=0, illegal_o=0, and counter and multiplier registers to 0.
REQ-028 SHALL, when rst_i is asserted mid-EXEC or mid-MUL, abort the operation and produce no valid_o after reset release.
REQ-029 SHALL accept a request on the first rising edge after rst_i deasserts if start_i is high.

Verification
REQ-030 SHALL cover: SUB with data1=5, data2=5, accepted at edge N -> ALUCtrl_o=100 and Zero_o=1 at edge N; data_o=0 and valid_o=1 at edge N+1.
REQ-031 SHALL cover: MUL with 0xFFFFFFFF x 3, accepted at edge N -> ready_o=0 for edges N..N+32; at edge N+32 data_o=0xFFFFFFFD and valid_o=1.
REQ-032 SHALL cover: SRAI with data1=0x80000000, data2=0x00000404 -> data_o=0xF8000000 and ALUCtrl_o=111; SLL with data1=1, data2=0x21 -> data_o=2.
REQ-033 SHALL cover: R-type with f7=0000000, f3=010 -> illegal_o=1, ALUCtrl_o=000, data_o=0, valid_o after 1 cycle.
REQ-034 SHALL cover: valid_o held for 5 cycles with ack_i=0 and start_i=1 throughout -> data_o unchanged, no new accept; on ack_i=1 -> IDLE, then the next request is accepted one cycle later.
REQ-035 SHALL cover: rst_i pulsed at MUL iteration 10 -> all outputs at reset values immediately, and valid_o never rises for the aborted MUL.
